module_bcd_7seg_scan: RTL

//  Downstream of the binary-to-BCD converter. Takes its 2-digit packed BCD word (tens, units).

---
 rtl/module_bcd_7seg_scan_pkg.sv | 48 ++++
 rtl/module_bcd_7seg_scan_seg7_decode.sv | 38 +++
 rtl/module_bcd_7seg_scan.sv | 139 +++++++++++++
 3 files changed

// File: rtl/module_bcd_7seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// module_bcd_7seg_scan_pkg
// Shared definitions for the 2-digit BCD 7-segment scanner:
//   - scan FSM state encoding (3-bit)
//   - active-high segment patterns {g,f,e,d,c,b,a} for 0-9 and the dash
//   - active-high anode / segment "off" constants and anode select codes
//   - polarity helpers used by the output stage
// ---------------------------------------------------------------------------
package module_bcd_7seg_scan_pkg;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_SHOW_U = 3'd1,
        ST_GAP_U  = 3'd2,
        ST_SHOW_T = 3'd3,
        ST_GAP_T  = 3'd4
    } scan_state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_PAT_0    = 7'h3F;
    localparam logic [6:0] SEG_PAT_1    = 7'h06;
    localparam logic [6:0] SEG_PAT_2    = 7'h5B;
    localparam logic [6:0] SEG_PAT_3    = 7'h4F;
    localparam logic [6:0] SEG_PAT_4    = 7'h66;
    localparam logic [6:0] SEG_PAT_5    = 7'h6D;
    localparam logic [6:0] SEG_PAT_6    = 7'h7D;
    localparam logic [6:0] SEG_PAT_7    = 7'h07;
    localparam logic [6:0] SEG_PAT_8    = 7'h7F;
    localparam logic [6:0] SEG_PAT_9    = 7'h6F;
    localparam logic [6:0] SEG_PAT_DASH = 7'h40;

    // Active-high "nothing lit" values
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [1:0] AN_OFF   = 2'b00;

    // Active-high anode selects: bit 0 = units, bit 1 = tens
    localparam logic [1:0] AN_UNITS = 2'b01;
    localparam logic [1:0] AN_TENS  = 2'b10;

    function automatic logic [6:0] seg_polarity(input logic [6:0] pat, input bit act_low);
        return act_low ? ~pat : pat;
    endfunction

    function automatic logic [1:0] an_polarity(input logic [1:0] sel, input bit act_low);
        return act_low ? ~sel : sel;
    endfunction

endpackage

// File: rtl/module_bcd_7seg_scan_seg7_decode.sv
// ---------------------------------------------------------------------------
// module_bcd_7seg_scan_seg7_decode
// Combinational BCD nibble to active-high 7-segment pattern.
// Ports:
//   nibble   in   4  BCD digit; values above 9 render as a dash
//   blank    in   1  forces all segments off regardless of nibble
//   pattern  out  7  {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module module_bcd_7seg_scan_seg7_decode
    import module_bcd_7seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);

    logic [6:0] digit_pat;

    always_comb begin
        digit_pat = SEG_PAT_DASH;
        case (nibble)
            4'd0:    digit_pat = SEG_PAT_0;
            4'd1:    digit_pat = SEG_PAT_1;
            4'd2:    digit_pat = SEG_PAT_2;
            4'd3:    digit_pat = SEG_PAT_3;
            4'd4:    digit_pat = SEG_PAT_4;
            4'd5:    digit_pat = SEG_PAT_5;
            4'd6:    digit_pat = SEG_PAT_6;
            4'd7:    digit_pat = SEG_PAT_7;
            4'd8:    digit_pat = SEG_PAT_8;
            4'd9:    digit_pat = SEG_PAT_9;
            default: digit_pat = SEG_PAT_DASH;
        endcase
    end

    assign pattern = blank ? SEG_OFF : digit_pat;

endmodule

// File: rtl/module_bcd_7seg_scan.sv
// ---------------------------------------------------------------------------
// module_bcd_7seg_scan
// Time-multiplexes a packed 2-digit BCD word onto a 2-digit common-anode
// 7-segment display with per-digit dead time and leading-zero blanking.
// The displayed value is captured once per frame so a digit pair never tears.
//
// Ports:
//   clk_i    in   1  clock, rising edge
//   rst_i    in   1  synchronous active-high reset
//   bcd_i    in   8  [7:4] tens, [3:0] units; captured only in LOAD
//   seg_o    out  7  {g,f,e,d,c,b,a}, registered, polarity per SEG_ACT_LOW
//   an_o     out  2  [0] units, [1] tens, registered, polarity per AN_ACT_LOW
//   frame_o  out  1  one-cycle pulse during the LOAD cycle
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_LOAD   | 1 cycle: capture bcd_i into shadow, all anodes off
// ST_SHOW_U | DIV_COUNT cycles: units anode on, units pattern driven
// ST_GAP_U  | BLANK_CYCLES cycles: everything off (anti-ghosting)
// ST_SHOW_T | DIV_COUNT cycles: tens anode on, tens pattern (or blank)
// ST_GAP_T  | BLANK_CYCLES cycles: everything off, then back to LOAD
//
// The cycle right after reset is spent in ST_LOAD with all outputs idle and
// frame_o low; the first real LOAD (with the frame_o pulse) follows it, so
// every frame_o pulse marks a complete, well-timed frame.
// ---------------------------------------------------------------------------
module module_bcd_7seg_scan
    import module_bcd_7seg_scan_pkg::*;
#(
    parameter int unsigned DIV_COUNT    = 27000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          AN_ACT_LOW   = 1'b1,
    parameter bit          BLANK_LZ     = 1'b1
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] bcd_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o,
    output logic       frame_o
);

    localparam int unsigned MAX_CNT = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [6:0] SEG_IDLE = seg_polarity(SEG_OFF, SEG_ACT_LOW);
    localparam logic [1:0] AN_IDLE  = an_polarity(AN_OFF, AN_ACT_LOW);

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shadow;
    logic [7:0]       shadow_nxt;
    logic             load_armed;

    logic [3:0]       dec_nibble;
    logic             dec_blank;
    logic [6:0]       dec_pattern;
    logic [1:0]       an_sel;

    // Next-state logic; each timed state leaves on its terminal count.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD:   state_nxt = load_armed ? ST_SHOW_U : ST_LOAD;
            ST_SHOW_U: if (cnt == DIV_LAST)   state_nxt = ST_GAP_U;
            ST_GAP_U:  if (cnt == BLANK_LAST) state_nxt = ST_SHOW_T;
            ST_SHOW_T: if (cnt == DIV_LAST)   state_nxt = ST_GAP_T;
            ST_GAP_T:  if (cnt == BLANK_LAST) state_nxt = ST_LOAD;
            default:   state_nxt = ST_LOAD;
        endcase
    end

    // The value used for decoding on the LOAD->SHOW_U edge is the one being
    // captured on that same edge, so the units digit appears without lag.
    assign shadow_nxt = (state == ST_LOAD) ? bcd_i : shadow;

    // Decoder input and anode select follow the state being entered, so the
    // registered outputs switch on the same edge as the state register.
    always_comb begin
        dec_nibble = shadow_nxt[3:0];
        dec_blank  = 1'b1;
        an_sel     = AN_OFF;
        unique case (state_nxt)
            ST_SHOW_U: begin
                dec_nibble = shadow_nxt[3:0];
                dec_blank  = 1'b0;
                an_sel     = AN_UNITS;
            end
            ST_SHOW_T: begin
                dec_nibble = shadow_nxt[7:4];
                dec_blank  = BLANK_LZ && (shadow_nxt[7:4] == 4'h0);
                an_sel     = AN_TENS;
            end
            default: begin
                dec_nibble = shadow_nxt[3:0];
                dec_blank  = 1'b1;
                an_sel     = AN_OFF;
            end
        endcase
    end

    module_bcd_7seg_scan_seg7_decode u_decode (
        .nibble  (dec_nibble),
        .blank   (dec_blank),
        .pattern (dec_pattern)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            shadow     <= 8'h00;
            load_armed <= 1'b0;
            seg_o      <= SEG_IDLE;
            an_o       <= AN_IDLE;
            frame_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            shadow     <= shadow_nxt;
            load_armed <= 1'b1;
            // Clearing on every state change keeps cnt inside 0..N-1.
            if ((state_nxt != state) || (state_nxt == ST_LOAD)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            seg_o   <= seg_polarity(dec_pattern, SEG_ACT_LOW);
            an_o    <= an_polarity(an_sel, AN_ACT_LOW);
            frame_o <= (state_nxt == ST_LOAD);
        end
    end

endmodule
